edge_capture: RTL
=================

EDGE_CAPTURE -- requirements
Module: edge_capture

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per channel (>=2).
REQ-003 Parameter FILTER_CYCLES, default 3, consecutive stable cycles needed to accept a new level (>=1).
REQ-004 Parameter IDLE_LEVEL, default 0, reset value of the synchronizer and filtered level (same for all channels).
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port in  input  CHANNELS  asynchronous raw inputs, one per channel.
REQ-008 Port mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 Port clear  input  CHANNELS  per-channel pending clear, level-sensitive, synchronous.
REQ-010 Port level  output  CHANNELS  filtered, synchronized level per channel.
REQ-011 Port pulse  output  CHANNELS  one-cycle registered event strobe per channel.
REQ-012 Port pending  output  CHANNELS  sticky event flag per channel.
REQ-013 Port irq  output  1  OR of all pending bits.

Function
REQ-014 Each channel shall pass in[i] through a SYNC_STAGES-deep flop chain; output s[i].
REQ-015 The filter shall hold a counter per channel; counter resets to 0 on any cycle with s[i]==level[i].
REQ-016 While s[i]!=level[i], counter increments; on the edge where counter==FILTER_CYCLES-1 and s[i]!=level[i], level[i] shall take s[i] and counter shall reset to 0.
REQ-017 A deviation of s[i] lasting fewer than FILTER_CYCLES cycles shall produce no level change and no event.
REQ-018 A level[i] change 0->1 is a rising edge, 1->0 a falling edge; it is an event if enabled by mode[i] sampled on the edge where level[i] changes.
REQ-019 pulse[i] shall be high for exactly the one cycle after the edge where level[i] changed with an enabled event; otherwise low.
REQ-020 Latency: counting the first clk edge sampling the new stable input as edge 1, pulse[i] shall be high after edge SYNC_STAGES+FILTER_CYCLES+1.
REQ-021 pending[i] shall set on the edge that asserts pulse[i]; clear[i] high on an edge shall reset it.
REQ-022 Simultaneous set and clear on the same edge: set wins, pending[i] stays 1.
REQ-023 mode 00 shall suppress pulse/pending but level[i] shall keep tracking; changing mode shall not clear pending.
REQ-024 irq shall be the combinational OR of the pending registers; no other logic between registers and irq.
REQ-025 Channels shall be fully independent; events on several channels on the same edge shall all be reported.

Reset
REQ-026 On rst_n low, asynchronously: synchronizer flops and level = IDLE_LEVEL, counters = 0, pulse = 0, pending = 0, irq = 0.
REQ-027 Reset asserted mid-filter or mid-pulse shall abort it; no event shall be reported for a transition in progress.
REQ-028 An input differing from IDLE_LEVEL at reset release shall be reported as an edge after the normal latency.

Configuration
REQ-029 Macro EDGE_CAPTURE_FILTER_EN: when defined, the filter counters of REQ-015..017 shall be compiled in.
REQ-030 When EDGE_CAPTURE_FILTER_EN is undefined, no counters shall exist; level[i] shall take s[i] on every edge, behaving exactly as FILTER_CYCLES=1 with FILTER_CYCLES ignored.

Verification (defaults, filter enabled)
REQ-031 mode[1:0]=01, in[0] 0->1 before edge 1, held -> pulse[0] high after edge 6 only, pending[0]=1, irq=1.
REQ-032 mode[1:0]=01, in[0] high for 2 cycles then low -> level[0], pulse[0], pending[0] stay 0.
REQ-033 mode=11 on ch1, in[1] 0->1 then 1->0 after 10 cycles -> two pulses on pulse[1], ten cycles apart.
REQ-034 ch2 pending=1, clear[2] high on the same edge pulse[2] rises -> pending[2] remains 1; clear next cycle -> 0, irq 0.
REQ-035 in[3] rising, rst_n low at edge 4 for 2 cycles -> no pulse; after release with in[3] still 1, pulse after 6 more edges.
REQ-036 Filter macro undefined, in[0] 0->1 -> pulse[0] high after edge 4; a 1-cycle glitch on s[0] produces a pulse.

Source files
------------

// File: rtl/edge_capture.sv
// Per-channel synchronize, glitch-filter and edge detect with sticky pending flags and an OR-ed irq.
// Pulse lags input by SYNC_STAGES+FILTER_CYCLES+1 edges; no backpressure. Filter counters exist only under EDGE_CAPTURE_FILTER_EN.
`timescale 1ns/1ps

module edge_capture #(
  parameter int   CHANNELS      = 4,
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 3,
  parameter logic IDLE_LEVEL    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CHANNELS-1:0]     in,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     clear,
  output logic [CHANNELS-1:0]     level,
  output logic [CHANNELS-1:0]     pulse,
  output logic [CHANNELS-1:0]     pending,
  output logic                    irq
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("edge_capture: CHANNELS must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("edge_capture: SYNC_STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("edge_capture: FILTER_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   level_q;
    logic                   level_nxt;
    logic                   rise;
    logic                   fall;
    logic                   event_q;
    logic                   pulse_q;
    logic                   pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_CAPTURE_FILTER_EN
    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    // Any cycle where s agrees with level restarts the stability count.
    always_comb begin
      cnt_nxt   = '0;
      level_nxt = level_q;
      if (s != level_q) begin
        if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
          level_nxt = s;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_nxt;
      end
    end
`else
    assign level_nxt = s;
`endif

    // Mode is qualified on the edge the level moves; the strobe follows one edge later.
    assign rise = level_nxt & ~level_q & mode[2*i];
    assign fall = ~level_nxt & level_q & mode[2*i+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q   <= IDLE_LEVEL;
        event_q   <= 1'b0;
        pulse_q   <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        level_q   <= level_nxt;
        event_q   <= rise | fall;
        pulse_q   <= event_q;
        pending_q <= event_q | (pending_q & ~clear[i]);
      end
    end

    assign level[i]   = level_q;
    assign pulse[i]   = pulse_q;
    assign pending[i] = pending_q;
  end

  assign irq = |pending;

endmodule
